iter_shifter: RTL and testbench

- Parametrised, multi-cycle successor to the ALU's single-cycle shifter.
- Performs SRL/SLL/SRA (optionally ROR/ROL) on a WIDTH-bit operand, at most STEP bit positions per clock.
- Uses valid/ready handshakes on input and output.
- Intended for area-constrained cores or wide datapaths where a full barrel shifter is too large.

---
 rtl/iter_shifter.sv | 127 ++++++++++++
 tb/tb_iter_shifter.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/iter_shifter.sv
// Multi-cycle SRL/SLL/SRA shifter, at most STEP bit positions per clock, valid/ready on both sides.
// Define ITER_SHIFTER_ROTATE_EN to add ROR/ROL (type 100/101); otherwise those encodings pass a through.
module iter_shifter #(
  parameter int WIDTH = 32,
  parameter int STEP  = 4,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [SHW-1:0]   shamt,
  input  logic [2:0]       shift_type,
  input  logic             cancel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] r,
  output logic             busy
);

  // state | meaning
  // IDLE  | waiting for a request, in_ready high
  // SHIFT | applying min(STEP, rem) positions per clock
  // DONE  | result on r, held until out_ready or cancel
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

  localparam logic [SHW:0] STEP_K  = (SHW+1)'(STEP);
  localparam logic [SHW:0] WIDTH_K = (SHW+1)'(WIDTH);

  state_t           state, state_nx;
  logic [WIDTH-1:0] work;
  logic [SHW-1:0]   rem;
  logic [2:0]       op;
  logic [SHW:0]     k;
  logic [SHW-1:0]   rem_left;
  logic [WIDTH-1:0] stepped;
  logic             is_pass;

  always_comb begin
    is_pass = 1'b1;
    case (shift_type)
      3'b000, 3'b001, 3'b010: is_pass = 1'b0;
`ifdef ITER_SHIFTER_ROTATE_EN
      3'b100, 3'b101:         is_pass = 1'b0;
`endif
      default:                is_pass = 1'b1;
    endcase
  end

  // k never reaches WIDTH here because rem < WIDTH, so the truncating cast is exact
  assign k        = ({1'b0, rem} >= STEP_K) ? STEP_K : {1'b0, rem};
  assign rem_left = rem - SHW'(k);

  always_comb begin
    stepped = work;
    case (op)
      3'b000:  stepped = work >> k;
      3'b001:  stepped = work << k;
      3'b010:  stepped = WIDTH'($signed(work) >>> k);
`ifdef ITER_SHIFTER_ROTATE_EN
      3'b100:  stepped = (work >> k) | (work << (WIDTH_K - k));
      3'b101:  stepped = (work << k) | (work >> (WIDTH_K - k));
`endif
      default: stepped = work;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (in_valid) state_nx = (shamt == '0 || is_pass) ? DONE : SHIFT;
      end
      SHIFT: begin
        if (cancel)                state_nx = IDLE;
        else if (rem_left == '0)   state_nx = DONE;
      end
      DONE: begin
        if (cancel || out_ready)   state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work <= '0;
      rem  <= '0;
      op   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            work <= a;
            rem  <= shamt;
            op   <= shift_type;
          end
        end
        SHIFT: begin
          if (cancel) begin
            rem <= '0;
          end else begin
            work <= stepped;
            rem  <= rem_left;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
  end

  assign r = work;

endmodule

// File: tb/tb_iter_shifter.sv
// Directed bench for iter_shifter (WIDTH=32, STEP=4) with an expected-result queue.
// Rotate expectations follow ITER_SHIFTER_ROTATE_EN.
module tb_iter_shifter;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [4:0]  shamt;
  logic [2:0]  shift_type;
  logic        cancel;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] r;
  logic        busy;

  int passed = 0;
  int total  = 0;
  logic [31:0] exp_q[$];

  iter_shifter #(.WIDTH(32), .STEP(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .shamt      (shamt),
    .shift_type (shift_type),
    .cancel     (cancel),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .r          (r),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
  endtask

  // Call #1 after an edge with the DUT idle; returns #1 after the accepting edge.
  task automatic send(input string tag, input logic [31:0] av, input logic [4:0] sh,
                      input logic [2:0] ty, input bit push, input logic [31:0] er);
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    a = av; shamt = sh; shift_type = ty; in_valid = 1'b1;
    if (push) exp_q.push_back(er);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Waits for out_valid, checks latency/result, optionally stalls, then completes the handshake.
  task automatic collect(input string tag, input int exp_lat, input int hold);
    int lat;
    bit rdy_seen;
    bit bad;
    logic [31:0] er;
    lat = 1; rdy_seen = 0; bad = 0;
    while (!out_valid && lat < 64) begin
      if (in_ready) rdy_seen = 1;
      @(posedge clk); #1;
      lat++;
    end
    if (in_ready) rdy_seen = 1;
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_in_ready_low"}, {31'd0, rdy_seen}, 32'd0);
    er = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    check({tag, "_r"}, r, er);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (r !== er || out_valid !== 1'b1 || in_ready !== 1'b0) bad = 1;
    end
    if (hold > 0) check({tag, "_hold"}, {31'd0, bad}, 32'd0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, "_idle_after"}, {30'd0, in_ready, out_valid}, 32'd2);
  endtask

  initial begin
    bit seen;
    rst_n = 1'b0; in_valid = 1'b0; a = '0; shamt = '0; shift_type = '0;
    cancel = 1'b0; out_ready = 1'b1;
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_r", r, 32'd0);
    #13 rst_n = 1'b1;
    @(posedge clk); #1;

    send("sra31", 32'h8000_0000, 5'd31, 3'b010, 1, 32'hFFFF_FFFF);
    check("sra31_busy", {31'd0, busy}, 32'd1);
    collect("sra31", 9, 0);

    send("srl5", 32'h8000_0000, 5'd5, 3'b000, 1, 32'h0400_0000);
    collect("srl5", 3, 0);

    // cancel in IDLE is ignored
    cancel = 1'b1;
    send("sll0", 32'h0000_0001, 5'd0, 3'b001, 1, 32'h0000_0001);
    cancel = 1'b0;
    collect("sll0", 1, 0);

    out_ready = 1'b0;
    send("bp", 32'h0000_000F, 5'd8, 3'b001, 1, 32'h0000_0F00);
    collect("bp", 3, 6);
    send("b2b", 32'h0000_00F0, 5'd4, 3'b000, 1, 32'h0000_000F);
    collect("b2b", 2, 0);

    send("cxl", 32'hFFFF_FFFF, 5'd20, 3'b000, 0, 32'h0);
    @(posedge clk); #1;
    cancel = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0;
    check("cxl_idle", {29'd0, in_ready, busy, out_valid}, 32'd4);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) seen = 1;
      @(posedge clk); #1;
    end
    check("cxl_no_out", {31'd0, seen}, 32'd0);
    send("post_cxl", 32'h0000_0001, 5'd1, 3'b001, 1, 32'h0000_0002);
    collect("post_cxl", 2, 0);

    send("rst_mid", 32'h8000_0000, 5'd31, 3'b010, 0, 32'h0);
    @(posedge clk); #1;
    check("rst_mid_busy_before", {31'd0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_outs", {29'd0, in_ready, busy, out_valid}, 32'd4);
    check("rst_mid_r", r, 32'd0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    send("post_rst", 32'h0000_0100, 5'd8, 3'b000, 1, 32'h0000_0001);
    collect("post_rst", 3, 0);

`ifdef ITER_SHIFTER_ROTATE_EN
    send("ror1", 32'h0000_0001, 5'd1, 3'b100, 1, 32'h8000_0000);
    collect("ror1", 2, 0);
    send("rol3", 32'hA000_0000, 5'd3, 3'b101, 1, 32'h0000_0005);
    collect("rol3", 2, 0);
`else
    send("ror1", 32'h0000_0001, 5'd1, 3'b100, 1, 32'h0000_0001);
    collect("ror1", 1, 0);
    send("rol3", 32'hA000_0000, 5'd3, 3'b101, 1, 32'hA000_0000);
    collect("rol3", 1, 0);
`endif

    send("pass", 32'h1234_5678, 5'd7, 3'b111, 1, 32'h1234_5678);
    collect("pass", 1, 0);

    check("queue_empty", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
